window_dot_product: RTL and testbench

- Stage directly downstream of shift_register in the convolver datapath.
- Consumes the parallel tap vector (data_out) each time a new sample is shifted in, multiplies each tap by a stored kernel weight, and sums the products.
- Emits one signed dot-product result per accepted window.
- Suppresses results until the shift register has been filled with SIZE valid samples.

---
 rtl/window_dot_product.sv | 130 +++++++++++++
 tb/tb_window_dot_product.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/window_dot_product.sv
// Windowed signed dot product of a shift-register tap vector against a stored kernel.
// Define WINDOW_DOT_PRODUCT_RELU_EN to clamp negative sums to zero in the output stage.
module window_dot_product #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH + $clog2(SIZE)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           shift_valid,
  input  logic                           flush,
  input  logic [SIZE*DATA_WIDTH-1:0]     window_in,
  input  logic                           weight_load,
  input  logic [SIZE*DATA_WIDTH-1:0]     weight_in,
  output logic signed [OUT_WIDTH-1:0]    result_out,
  output logic                           result_valid,
  output logic                           window_ready
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int CW = $clog2(SIZE+1);
  localparam logic [CW-1:0] FULL   = CW'(SIZE);
  localparam logic [CW-1:0] ALMOST = CW'(SIZE-1);

  logic [CW-1:0]               r_count;
  logic                        r_window_ready;
  logic [SIZE*DATA_WIDTH-1:0]  r_weights;
  logic signed [PW-1:0]        r_prod [SIZE];
  logic                        r_v1;
  logic signed [OUT_WIDTH-1:0] r_result;
  logic                        r_result_valid;

  logic                        w_launch;
  logic signed [PW-1:0]        w_prod [SIZE];
  logic signed [OUT_WIDTH-1:0] w_sum;
  logic signed [OUT_WIDTH-1:0] w_stage2;

  // The SIZE-th accepted sample and every later one launch a window; flush blocks it.
  assign w_launch = shift_valid && !flush && ((r_count == FULL) || (r_count == ALMOST));

  // Per-tap signed products against the current (pre-update) weights
  always_comb begin
    for (int k = 0; k < SIZE; k++) begin
      w_prod[k] = PW'($signed(window_in[k*DATA_WIDTH +: DATA_WIDTH]))
                * PW'($signed(r_weights[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Sign-extended sum of the registered products, optionally rectified
  always_comb begin
    w_sum = {OUT_WIDTH{1'b0}};
    for (int k = 0; k < SIZE; k++) begin
      w_sum = w_sum + OUT_WIDTH'(r_prod[k]);
    end
`ifdef WINDOW_DOT_PRODUCT_RELU_EN
    if (w_sum[OUT_WIDTH-1]) begin
      w_stage2 = {OUT_WIDTH{1'b0}};
    end else begin
      w_stage2 = w_sum;
    end
`else
    w_stage2 = w_sum;
`endif
  end

  // Fill counter saturating at SIZE; window_ready mirrors the counter being full
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count        <= {CW{1'b0}};
      r_window_ready <= 1'b0;
    end else if (flush) begin
      r_count        <= {CW{1'b0}};
      r_window_ready <= 1'b0;
    end else if (shift_valid && (r_count != FULL)) begin
      r_count        <= r_count + CW'(1);
      r_window_ready <= (r_count == ALMOST);
    end else begin
      r_count        <= r_count;
      r_window_ready <= (r_count == FULL);
    end
  end

  // Kernel weight register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_weights <= {(SIZE*DATA_WIDTH){1'b0}};
    end else if (weight_load) begin
      r_weights <= weight_in;
    end else begin
      r_weights <= r_weights;
    end
  end

  // Stage 1: products and their valid bit; flush deliberately does not clear in-flight work
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SIZE; k++) begin
        r_prod[k] <= {PW{1'b0}};
      end
      r_v1 <= 1'b0;
    end else begin
      if (w_launch) begin
        r_prod <= w_prod;
      end else begin
        r_prod <= r_prod;
      end
      r_v1 <= w_launch;
    end
  end

  // Stage 2: accumulate; result_out holds between strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result       <= {OUT_WIDTH{1'b0}};
      r_result_valid <= 1'b0;
    end else begin
      if (r_v1) begin
        r_result <= w_stage2;
      end else begin
        r_result <= r_result;
      end
      r_result_valid <= r_v1;
    end
  end

  assign result_out   = r_result;
  assign result_valid = r_result_valid;
  assign window_ready = r_window_ready;

endmodule

// File: tb/tb_window_dot_product.sv
// Directed self-checking bench for window_dot_product (default parameters).
module tb_window_dot_product;

  localparam int SIZE = 3;
  localparam int DW   = 32;
  localparam int OW   = 2*DW + $clog2(SIZE);

  logic                   clock;
  logic                   reset;
  logic                   shift_valid;
  logic                   flush;
  logic [SIZE*DW-1:0]     window_in;
  logic                   weight_load;
  logic [SIZE*DW-1:0]     weight_in;
  logic signed [OW-1:0]   result_out;
  logic                   result_valid;
  logic                   window_ready;

  int n_cmp;
  int n_err;

  window_dot_product dut (
    .clock        (clock),
    .reset        (reset),
    .shift_valid  (shift_valid),
    .flush        (flush),
    .window_in    (window_in),
    .weight_load  (weight_load),
    .weight_in    (weight_in),
    .result_out   (result_out),
    .result_valid (result_valid),
    .window_ready (window_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [SIZE*DW-1:0] pack3(input logic signed [DW-1:0] t0,
                                               input logic signed [DW-1:0] t1,
                                               input logic signed [DW-1:0] t2);
    return {t2, t1, t0};
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs settle and inputs may change 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic sv, input logic [SIZE*DW-1:0] win);
    shift_valid = sv;
    window_in   = win;
    tick();
    shift_valid = 1'b0;
  endtask

  task automatic load_w(input logic [SIZE*DW-1:0] w);
    weight_load = 1'b1;
    weight_in   = w;
    tick();
    weight_load = 1'b0;
  endtask

  logic signed [OW-1:0] exp_neg;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    shift_valid = 1'b0;
    flush = 1'b0;
    window_in = '0;
    weight_load = 1'b0;
    weight_in = '0;

    #2;
    check("rst_result", result_out, '0);
    check("rst_valid", {65'd0, result_valid}, '0);
    check("rst_ready", {65'd0, window_ready}, '0);
    #10 reset = 1'b1;

    // Fill and first results
    load_w(pack3(1, 2, 3));
    step(1'b1, pack3(5, 0, 0));
    check("fill1_valid", {65'd0, result_valid}, '0);
    step(1'b1, pack3(6, 5, 0));
    check("fill2_valid", {65'd0, result_valid}, '0);
    check("fill2_ready", {65'd0, window_ready}, '0);
    step(1'b1, pack3(7, 6, 5));
    check("fill3_valid", {65'd0, result_valid}, '0);
    check("fill3_ready", {65'd0, window_ready}, 66'd1);
    step(1'b1, pack3(8, 7, 6));
    check("first_valid", {65'd0, result_valid}, 66'd1);
    check("first_result", result_out, 66'd34);
    step(1'b0, '0);
    check("b2b_valid", {65'd0, result_valid}, 66'd1);
    check("b2b_result", result_out, 66'd40);
    step(1'b0, '0);
    check("idle_valid", {65'd0, result_valid}, '0);
    check("hold_result", result_out, 66'd40);

    // Negative sum
    load_w(pack3(-1, 0, 0));
    step(1'b1, pack3(9, 0, 0));
    step(1'b0, '0);
`ifdef WINDOW_DOT_PRODUCT_RELU_EN
    exp_neg = '0;
`else
    exp_neg = -66'sd9;
`endif
    check("neg_valid", {65'd0, result_valid}, 66'd1);
    check("neg_result", result_out, exp_neg);

    // Weight load coincident with a launch
    load_w(pack3(1, 2, 3));
    weight_load = 1'b1;
    weight_in   = pack3(2, 2, 2);
    step(1'b1, pack3(1, 1, 1));
    weight_load = 1'b0;
    step(1'b1, pack3(1, 1, 1));
    check("wl_old_valid", {65'd0, result_valid}, 66'd1);
    check("wl_old_result", result_out, 66'd6);
    step(1'b1, pack3(1, 0, 0));
    check("wl_new_result", result_out, 66'd6);
    step(1'b0, '0);
    check("wl_confirm_valid", {65'd0, result_valid}, 66'd1);
    check("wl_confirm_result", result_out, 66'd2);
    step(1'b0, '0);

    // Flush with shift_valid while a result is in flight
    step(1'b1, pack3(1, 2, 3));
    flush = 1'b1;
    step(1'b1, pack3(4, 4, 4));
    flush = 1'b0;
    check("flush_inflight_valid", {65'd0, result_valid}, 66'd1);
    check("flush_inflight_result", result_out, 66'd12);
    check("flush_ready", {65'd0, window_ready}, '0);
    step(1'b0, '0);
    check("flush_nolaunch", {65'd0, result_valid}, '0);
    step(1'b1, pack3(1, 0, 0));
    check("refill1_valid", {65'd0, result_valid}, '0);
    step(1'b1, pack3(1, 1, 0));
    check("refill2_valid", {65'd0, result_valid}, '0);
    check("refill2_ready", {65'd0, window_ready}, '0);
    step(1'b1, pack3(1, 1, 1));
    check("refill3_valid", {65'd0, result_valid}, '0);
    check("refill3_ready", {65'd0, window_ready}, 66'd1);
    step(1'b0, '0);
    check("refill_valid", {65'd0, result_valid}, 66'd1);
    check("refill_result", result_out, 66'd6);
    step(1'b0, '0);

    // Reset while a window is in flight
    step(1'b1, pack3(5, 5, 5));
    reset = 1'b0;
    #1;
    check("midrst_result", result_out, '0);
    check("midrst_valid", {65'd0, result_valid}, '0);
    check("midrst_ready", {65'd0, window_ready}, '0);
    tick();
    reset = 1'b1;
    step(1'b0, '0);
    check("postrst_valid1", {65'd0, result_valid}, '0);
    step(1'b0, '0);
    check("postrst_valid2", {65'd0, result_valid}, '0);
    step(1'b1, pack3(1, 0, 0));
    step(1'b1, pack3(1, 1, 0));
    step(1'b1, pack3(1, 1, 1));
    check("postrst_noresult", {65'd0, result_valid}, '0);
    step(1'b0, '0);
    check("postrst_refill_valid", {65'd0, result_valid}, 66'd1);
    check("postrst_zero_weights", result_out, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
